// File: rtl/multi_mode_ping_pong_counter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ppc_pkg
// Description : Shared constants for the multi-mode ping-pong counter:
//               counting-mode encodings, mode width and turn-counter width.
//               Optional feature macro: PPC_TURN_COUNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
package ppc_pkg;

   localparam int MODE_W     = 2;
   localparam int TURN_CNT_W = 16;

   typedef logic [MODE_W-1:0] ppc_mode_t;

   localparam ppc_mode_t PPC_PINGPONG  = 2'b00;
   localparam ppc_mode_t PPC_WRAP_UP   = 2'b01;
   localparam ppc_mode_t PPC_WRAP_DOWN = 2'b10;
   localparam ppc_mode_t PPC_ONESHOT   = 2'b11;

endpackage : ppc_pkg
`default_nettype wire

// File: rtl/multi_mode_ping_pong_counter_if.sv
`default_nettype none
// ============================================================================
// Interface   : multi_mode_ping_pong_counter_if
// Description : Control/status bundle of the multi-mode ping-pong counter.
//               master = driver of controls, slave = the counter itself.
//               turn_cnt exists only when PPC_TURN_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_mode_ping_pong_counter_if #(
   parameter int WIDTH = 4
);
   import ppc_pkg::*;

   logic             enable;
   ppc_mode_t        mode;
   logic             flip;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] max;
   logic [WIDTH-1:0] min;
   logic             direction;
   logic [WIDTH-1:0] out;
   logic             hold;
   logic             turn;
   logic             done;
`ifdef PPC_TURN_COUNT_EN
   logic [TURN_CNT_W-1:0] turn_cnt;
`endif

   modport master (
      output enable, mode, flip, load, load_val, step, max, min,
`ifdef PPC_TURN_COUNT_EN
      input  turn_cnt,
`endif
      input  direction, out, hold, turn, done
   );

   modport slave (
      input  enable, mode, flip, load, load_val, step, max, min,
`ifdef PPC_TURN_COUNT_EN
      output turn_cnt,
`endif
      output direction, out, hold, turn, done
   );

endinterface : multi_mode_ping_pong_counter_if
`default_nettype wire

// File: rtl/multi_mode_ping_pong_counter_next_state.sv
`default_nettype none
// ============================================================================
// Module      : ppc_next_state
// Description : Combinational count step for one enabled, primed, non-held,
//               non-load cycle. All arithmetic is WIDTH+1 bits and every
//               result is clamped into [min,max].
// Revision    : 1.0 - initial release
// ============================================================================
module ppc_next_state
   import ppc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  wire logic [WIDTH-1:0] out_cur,
   input  wire logic             dir_cur,
   input  wire logic             done_cur,
   input  wire ppc_mode_t        mode,
   input  wire logic             mode_changed,
   input  wire logic             flip,
   input  wire logic [WIDTH-1:0] step,
   input  wire logic [WIDTH-1:0] max,
   input  wire logic [WIDTH-1:0] min,
   output logic      [WIDTH-1:0] out_nxt,
   output logic                  dir_nxt,
   output logic                  turn_nxt,
   output logic                  done_nxt
);

   logic [WIDTH:0]   w_up_sum;
   logic [WIDTH:0]   w_dn_diff;
   logic [WIDTH-1:0] w_up_clamp;
   logic [WIDTH-1:0] w_dn_clamp;
   logic             w_step_nz;

   // One step up / down, saturated at the bounds (extra bit catches overflow and borrow)
   always_comb begin
      w_up_sum   = {1'b0, out_cur} + {1'b0, step};
      w_dn_diff  = {1'b0, out_cur} - {1'b0, step};
      w_up_clamp = (w_up_sum > {1'b0, max}) ? max : w_up_sum[WIDTH-1:0];
      w_dn_clamp = (w_dn_diff[WIDTH] || (w_dn_diff[WIDTH-1:0] < min)) ? min
                                                                     : w_dn_diff[WIDTH-1:0];
      w_step_nz  = (step != '0);
   end

   // Mode-specific next value, direction, turn pulse and done flag
   always_comb begin
      out_nxt  = out_cur;
      dir_nxt  = dir_cur;
      turn_nxt = 1'b0;
      done_nxt = mode_changed ? 1'b0 : done_cur;
      case (mode)
         PPC_PINGPONG: begin
            if (flip) begin
               // Reverse first, then take one step in the new direction
               dir_nxt = ~dir_cur;
               out_nxt = dir_cur ? w_dn_clamp : w_up_clamp;
            end else if (w_step_nz) begin
               if (dir_cur) begin
                  if (out_cur == max) begin
                     dir_nxt  = 1'b0;
                     out_nxt  = w_dn_clamp;
                     turn_nxt = 1'b1;
                  end else begin
                     out_nxt = w_up_clamp;
                  end
               end else begin
                  if (out_cur == min) begin
                     dir_nxt  = 1'b1;
                     out_nxt  = w_up_clamp;
                     turn_nxt = 1'b1;
                  end else begin
                     out_nxt = w_dn_clamp;
                  end
               end
            end
         end
         PPC_WRAP_UP: begin
            dir_nxt = 1'b1;
            if (w_step_nz) begin
               if (out_cur == max) begin
                  out_nxt  = min;
                  turn_nxt = 1'b1;
               end else begin
                  out_nxt = w_up_clamp;
               end
            end
         end
         PPC_WRAP_DOWN: begin
            dir_nxt = 1'b0;
            if (w_step_nz) begin
               if (out_cur == min) begin
                  out_nxt  = max;
                  turn_nxt = 1'b1;
               end else begin
                  out_nxt = w_dn_clamp;
               end
            end
         end
         default: begin
            // One-shot: climb to max, then freeze until load/reset/mode change
            dir_nxt = 1'b1;
            if (!done_nxt) begin
               out_nxt  = w_up_clamp;
               done_nxt = (w_up_clamp == max);
            end
         end
      endcase
   end

endmodule : ppc_next_state
`default_nettype wire

// File: rtl/multi_mode_ping_pong_counter.sv
`default_nettype none
// ============================================================================
// Module      : multi_mode_ping_pong_counter
// Description : Parameterised bounded counter with ping-pong, wrap-up,
//               wrap-down and one-shot modes, programmable step, load,
//               priming after reset and a registered turn pulse.
//               Define PPC_TURN_COUNT_EN to add the saturating turn_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_mode_ping_pong_counter
   import ppc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input wire logic clk,
   input wire logic rst_n,
   multi_mode_ping_pong_counter_if.slave bus
);

   logic [WIDTH-1:0] out_q, out_d;
   logic             dir_q, dir_d;
   logic             turn_q, turn_d;
   logic             done_q, done_d;
   logic             primed_q, primed_d;
   ppc_mode_t        mode_q, mode_d;

   logic [WIDTH-1:0] w_ns_out;
   logic             w_ns_dir;
   logic             w_ns_turn;
   logic             w_ns_done;
   logic             w_hold;
   logic             w_mode_changed;

`ifdef PPC_TURN_COUNT_EN
   localparam logic [TURN_CNT_W-1:0] TURN_CNT_MAX = '1;
   logic [TURN_CNT_W-1:0] turn_cnt_q, turn_cnt_d;
`endif

   // Invalid bounds or an out-of-range value freeze the counter in the same cycle
   always_comb begin
      w_hold = (bus.max < bus.min) | (out_q < bus.min) | (out_q > bus.max) |
               (bus.max == bus.min);
      w_mode_changed = (bus.mode != mode_q);
   end

   ppc_next_state #(
      .WIDTH (WIDTH)
   ) u_next_state (
      .out_cur      (out_q),
      .dir_cur      (dir_q),
      .done_cur     (done_q),
      .mode         (bus.mode),
      .mode_changed (w_mode_changed),
      .flip         (bus.flip),
      .step         (bus.step),
      .max          (bus.max),
      .min          (bus.min),
      .out_nxt      (w_ns_out),
      .dir_nxt      (w_ns_dir),
      .turn_nxt     (w_ns_turn),
      .done_nxt     (w_ns_done)
   );

   // Precedence per enabled cycle: prime > load > hold > count (flip handled in count)
   always_comb begin
      out_d    = out_q;
      dir_d    = dir_q;
      turn_d   = 1'b0;
      done_d   = done_q;
      primed_d = primed_q;
      mode_d   = mode_q;
`ifdef PPC_TURN_COUNT_EN
      turn_cnt_d = turn_cnt_q;
`endif
      if (bus.enable) begin
         mode_d = bus.mode;
         if (!primed_q) begin
            out_d    = bus.min;
            dir_d    = 1'b1;
            done_d   = 1'b0;
            primed_d = 1'b1;
         end else if (bus.load) begin
            out_d  = bus.load_val;
            dir_d  = 1'b1;
            done_d = 1'b0;
`ifdef PPC_TURN_COUNT_EN
            turn_cnt_d = '0;
`endif
         end else if (!w_hold) begin
            out_d  = w_ns_out;
            dir_d  = w_ns_dir;
            turn_d = w_ns_turn;
            done_d = w_ns_done;
`ifdef PPC_TURN_COUNT_EN
            if (w_ns_turn && (turn_cnt_q != TURN_CNT_MAX)) begin
               turn_cnt_d = turn_cnt_q + 1'b1;
            end
`endif
         end
      end
   end

   // State registers; asynchronous reset returns to the un-primed state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= '0;
         dir_q    <= 1'b1;
         turn_q   <= 1'b0;
         done_q   <= 1'b0;
         primed_q <= 1'b0;
         mode_q   <= PPC_PINGPONG;
      end else begin
         out_q    <= out_d;
         dir_q    <= dir_d;
         turn_q   <= turn_d;
         done_q   <= done_d;
         primed_q <= primed_d;
         mode_q   <= mode_d;
      end
   end

`ifdef PPC_TURN_COUNT_EN
   // Saturating count of turn pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         turn_cnt_q <= '0;
      end else begin
         turn_cnt_q <= turn_cnt_d;
      end
   end

   assign bus.turn_cnt = turn_cnt_q;
`endif

   assign bus.out       = out_q;
   assign bus.direction = dir_q;
   assign bus.turn      = turn_q;
   assign bus.done      = done_q;
   assign bus.hold      = w_hold;

endmodule : multi_mode_ping_pong_counter
`default_nettype wire

// File: tb/tb_multi_mode_ping_pong_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_mode_ping_pong_counter
// Description : Directed self-checking bench for multi_mode_ping_pong_counter
//               (WIDTH=4). Extra turn_cnt check when PPC_TURN_COUNT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_mode_ping_pong_counter;
   import ppc_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   multi_mode_ping_pong_counter_if #(.WIDTH(4)) bus ();

   multi_mode_ping_pong_counter #(
      .WIDTH (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_st(input string tag, input logic [3:0] e_out, input logic e_dir,
                           input logic e_turn);
      check_eq({tag, ".out"},  32'(bus.out),       32'(e_out));
      check_eq({tag, ".dir"},  32'(bus.direction), 32'(e_dir));
      check_eq({tag, ".turn"}, 32'(bus.turn),      32'(e_turn));
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      bus.enable   = 1'b0;
      bus.mode     = PPC_PINGPONG;
      bus.flip     = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = 4'd0;
      bus.step     = 4'd1;
      bus.max      = 4'd9;
      bus.min      = 4'd2;

      // Reset and priming
      #12;
      check_st("rst", 4'd0, 1'b1, 1'b0);
      check_eq("rst.done", 32'(bus.done), 32'd0);
      check_eq("rst.hold", 32'(bus.hold), 32'd1);
      rst_n      = 1'b1;
      bus.enable = 1'b1;
      tick(); check_st("prime", 4'd2, 1'b1, 1'b0);
      tick(); check_st("cnt3",  4'd3, 1'b1, 1'b0);
      tick(); check_st("cnt4",  4'd4, 1'b1, 1'b0);

      // Ping-pong bounce with step 3
      bus.load = 1'b1; bus.load_val = 4'd8; bus.step = 4'd3;
      tick(); check_st("ld8", 4'd8, 1'b1, 1'b0);
      bus.load = 1'b0;
      tick(); check_st("b9", 4'd9, 1'b1, 1'b0);
      tick(); check_st("b6", 4'd6, 1'b0, 1'b1);
      tick(); check_st("b3", 4'd3, 1'b0, 1'b0);
      tick(); check_st("b2", 4'd2, 1'b0, 1'b0);
      tick(); check_st("b5", 4'd5, 1'b1, 1'b1);

      // Flip in ping-pong, ignored in wrap-up
      bus.load = 1'b1; bus.load_val = 4'd5; bus.step = 4'd1;
      tick(); check_st("ld5", 4'd5, 1'b1, 1'b0);
      bus.load = 1'b0; bus.flip = 1'b1;
      tick(); check_st("flip", 4'd4, 1'b0, 1'b0);
      bus.mode = PPC_WRAP_UP;
      tick(); check_st("wupflip", 4'd5, 1'b1, 1'b0);
      bus.flip = 1'b0;

      // Wrap-up and wrap-down wrap points
      bus.min = 4'd0; bus.max = 4'd15; bus.load = 1'b1; bus.load_val = 4'd15;
      tick(); check_st("ld15", 4'd15, 1'b1, 1'b0);
      bus.load = 1'b0;
      tick(); check_st("wup", 4'd0, 1'b1, 1'b1);
      bus.mode = PPC_WRAP_DOWN;
      tick(); check_st("wdn", 4'd15, 1'b0, 1'b1);
      tick(); check_st("wdn14", 4'd14, 1'b0, 1'b0);

      // One-shot with step 4 from 0
      bus.mode = PPC_ONESHOT; bus.step = 4'd4; bus.load = 1'b1; bus.load_val = 4'd0;
      tick(); check_st("os0", 4'd0, 1'b1, 1'b0);
      bus.load = 1'b0;
      tick(); check_eq("os4",  32'(bus.out), 32'd4);
      tick(); check_eq("os8",  32'(bus.out), 32'd8);
      tick(); check_eq("os12", 32'(bus.out), 32'd12);
      check_eq("os12.done", 32'(bus.done), 32'd0);
      tick(); check_eq("os15", 32'(bus.out), 32'd15);
      tick(); check_eq("os15b", 32'(bus.out), 32'd15);
      check_eq("os.done", 32'(bus.done), 32'd1);
      tick(); check_eq("os15c", 32'(bus.out), 32'd15);
      check_eq("os.done2", 32'(bus.done), 32'd1);

      // Hold on inverted bounds, enable gating, then load inside bounds
      bus.mode = PPC_PINGPONG; bus.max = 4'd3; bus.min = 4'd5; bus.step = 4'd1;
      #1; check_eq("hold.inv", 32'(bus.hold), 32'd1);
      tick(); check_eq("hold.out", 32'(bus.out), 32'd15);
      bus.enable = 1'b0; bus.load = 1'b1; bus.load_val = 4'd7; bus.max = 4'd9; bus.min = 4'd2;
      tick(); check_eq("dis.out", 32'(bus.out), 32'd15);
      check_eq("dis.hold", 32'(bus.hold), 32'd1);
      bus.enable = 1'b1;
      tick(); check_st("ld7", 4'd7, 1'b1, 1'b0);
      check_eq("ld7.hold", 32'(bus.hold), 32'd0);
      check_eq("ld7.done", 32'(bus.done), 32'd0);
      bus.load = 1'b0; bus.flip = 1'b1;
      tick(); check_st("pre.rst", 4'd6, 1'b0, 1'b0);
      bus.flip = 1'b0;

      // Asynchronous reset mid-cycle, then re-prime
      #3; rst_n = 1'b0;
      #1; check_st("arst", 4'd0, 1'b1, 1'b0);
`ifdef PPC_TURN_COUNT_EN
      check_eq("arst.tcnt", 32'(bus.turn_cnt), 32'd0);
`endif
      #2; rst_n = 1'b1;
      tick(); check_st("reprime", 4'd2, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_multi_mode_ping_pong_counter
`default_nettype wire
